// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / divide unit.
// One operation takes 33 cycles after the start edge: 32 iterations (shift-add
// for multiply, restoring shift-subtract for divide), then one finish cycle that
// applies sign correction and writes hi/lo.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;       // 1: divide, 0: multiply
  logic        neg_q_q, neg_q_d;   // negate product / quotient
  logic        neg_r_q, neg_r_d;   // negate remainder (dividend was negative)
  logic [31:0] opnd_q, opnd_d;     // multiplicand (mult) or divisor (div)
  logic [63:0] acc_q, acc_d;       // mult: {partial, multiplier}; div: {rem, quot}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        sgn, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_sub;
  logic [63:0] prod_neg;
  logic [31:0] quo_neg, rem_neg;

  // State and datapath registers; reset clears everything, discarding any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state, iteration step and result write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    sgn   = ~op[0];
    a_neg = sgn & srcA[31];
    b_neg = sgn & srcB[31];
    mag_a = a_neg ? (~srcA + 32'd1) : srcA;
    mag_b = b_neg ? (~srcB + 32'd1) : srcB;

    sum     = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    rem_sh  = acc_q[63:31];
    fits    = (rem_sh >= {1'b0, opnd_q});
    // A successful subtract always leaves a remainder below the divisor, so 32 bits suffice.
    rem_sub = acc_q[62:31] - opnd_q;

    prod_neg = ~acc_q + 64'd1;
    quo_neg  = ~acc_q[31:0] + 32'd1;
    rem_neg  = ~acc_q[63:32] + 32'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          div_d   = op[1];
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          opnd_d  = op[1] ? mag_b : mag_a;
          acc_d   = {32'd0, (op[1] ? mag_a : mag_b)};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (div_q) begin
          acc_d = fits ? {rem_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (div_q) begin
          // Divide by zero leaves rem = |dividend| (restored to srcA by the sign fix);
          // the quotient is forced to all ones regardless of operand signs.
          lo_d = (opnd_q == 32'd0) ? '1 : (neg_q_q ? quo_neg : acc_q[31:0]);
          hi_d = neg_r_q ? rem_neg : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = neg_q_q ? prod_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed test of mult_div_unit with hand-computed results.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, follow it to done and check latency, busy time, hold and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit interfere);
    int n;
    int busy_n;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    busy_n = (busy === 1'b1) ? 1 : 0;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy === 1'b1) busy_n++;
      if (n == 16) begin
        chk({tag, " hold hi"}, hi, prev_hi);
        chk({tag, " hold lo"}, lo, prev_lo);
      end
      if (interfere && n == 10) begin
        @(negedge clk);
        start = 1'b1; op = DIV; srcA = 32'd99; srcB = 32'd5;
      end
      if (interfere && n == 11) begin
        @(negedge clk);
        start = 1'b0; op = MULT; srcA = 32'hDEADBEEF;
      end
    end
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " busy cycles"}, 32'(busy_n), 32'd33);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    prev_hi = eh;
    prev_lo = el;
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    chk({tag, " hi held"}, hi, eh);
  endtask

  initial begin : stim
    int n;
    int done_n;
    rst_n = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult -3*7", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mult -2*-3", MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'd6, 1'b0);
    run_op("mult min*min", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_op("divu 100/0", DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b0);
    run_op("div -5/0", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("multu 6*7 restart", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);

    // start held high across the finish edge: next op accepted one edge later.
    @(negedge clk);
    start = 1'b1; op = MULTU; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held start first latency", 32'(n), 32'd33);
    chk("held start first lo", lo, 32'd15);
    srcA = 32'd4;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("held start rearm busy", {31'd0, busy}, 32'd1);
    end while (done !== 1'b1 && n < 100);
    chk("held start second gap", 32'(n), 32'd34);
    chk("held start second lo", lo, 32'd20);
    @(negedge clk);
    start = 1'b0;
    prev_hi = 32'd0;
    prev_lo = 32'd20;

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = DIVU; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midop reset busy", {31'd0, busy}, 32'd0);
    chk("midop reset done", {31'd0, done}, 32'd0);
    chk("midop reset hi", hi, 32'd0);
    chk("midop reset lo", lo, 32'd20 & 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_n++;
    end
    chk("no done after reset", 32'(done_n), 32'd0);
    chk("idle after reset", {31'd0, busy}, 32'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    run_op("divu 100/7 after reset", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
